// File: rtl/strait_tile_sequencer_if.sv
// Bundle of every signal between the STRAIT tile sequencer and its
// neighbours: host control, BISR allocation, weight source, activation
// memory read port and accumulator write port.
//
// Handshake: a weight row moves on a cycle where w_in_valid and w_in_ready
// are both 1. The source may raise w_in_valid at any time and must hold it
// until the row is taken; the sequencer raises w_in_ready only while it is
// loading weights, and weight_valid marks exactly the cycles a row moves.
interface strait_tile_sequencer_if #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
);
    // Host side
    logic                  test_mode;
    logic                  start;
    logic [ADDR_WIDTH:0]   vec_count;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic                  aborted;
    // BISR allocation
    logic                  alloc_start;
    logic                  recovery_done;
    logic                  recovery_success;
    // Weight row stream
    logic                  w_in_valid;
    logic                  w_in_ready;
    logic                  weight_valid;
    // Activation read and accumulator write ports
    logic                  act_rd_en;
    logic [ADDR_WIDTH-1:0] act_rd_addr;
    logic                  acc_wr_en;
    logic [ADDR_WIDTH-1:0] acc_wr_addr;
    // FSM state for observation
    logic [2:0]            state_dbg;

    modport master (
        output test_mode, start, vec_count, recovery_done, recovery_success, w_in_valid,
        input  busy, done, error, aborted, alloc_start, w_in_ready, weight_valid,
               act_rd_en, act_rd_addr, acc_wr_en, acc_wr_addr, state_dbg
    );

    modport slave (
        input  test_mode, start, vec_count, recovery_done, recovery_success, w_in_valid,
        output busy, done, error, aborted, alloc_start, w_in_ready, weight_valid,
               act_rd_en, act_rd_addr, acc_wr_en, acc_wr_addr, state_dbg
    );
endinterface

// File: rtl/strait_tile_sequencer.sv
// Normal-mode tile job sequencer for the STRAIT datapath. Per job it kicks
// BISR weight allocation, meters SYSTOLIC_SIZE weight rows into BISR, streams
// vec_count activation read addresses, and replays those addresses
// ARRAY_LATENCY cycles later as accumulator writes. test_mode aborts any job.
module strait_tile_sequencer #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
    parameter int ARRAY_LATENCY = 2 * SYSTOLIC_SIZE
) (
    input logic                    clk,
    input logic                    rst,
    strait_tile_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ALLOC  = 3'd1,
        S_LOAD_W = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_FIN    = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   VEC_MAX  = (ADDR_WIDTH + 1)'(SYSTOLIC_SIZE);

    state_e                state_q;
    logic [ADDR_WIDTH:0]   vec_q;
    logic [ADDR_WIDTH-1:0] row_cnt_q;
    logic [ADDR_WIDTH-1:0] addr_cnt_q;
    logic                  alloc_start_q;
    logic                  error_q;
    logic                  aborted_q;

    // Delay line modelling the array: entry 0 is the newest read.
    logic                  dl_vld_q  [ARRAY_LATENCY];
    logic [ADDR_WIDTH-1:0] dl_addr_q [ARRAY_LATENCY];

    logic                  abort;
    logic                  pending;
    logic                  w_ready;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  vec_bad;

    assign abort   = (state_q != S_IDLE) && bus.test_mode;
    assign w_ready = (state_q == S_LOAD_W);
    assign rd_en   = (state_q == S_STREAM);
    assign rd_addr = rd_en ? addr_cnt_q : '0;
    assign vec_bad = (bus.vec_count == '0) || (bus.vec_count > VEC_MAX);

    // Reads still inside the array, excluding the one leaving this cycle;
    // once clear, the current cycle carries the final accumulator write.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < ARRAY_LATENCY - 1; i++) begin
            pending = pending | dl_vld_q[i];
        end
    end

    // Job FSM with its counters and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            vec_q         <= '0;
            row_cnt_q     <= '0;
            addr_cnt_q    <= '0;
            alloc_start_q <= 1'b0;
            error_q       <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            alloc_start_q <= 1'b0;
            aborted_q     <= 1'b0;
            if (abort) begin
                // BIST takes the datapath: drop the job silently, keep error.
                state_q    <= S_IDLE;
                aborted_q  <= 1'b1;
                row_cnt_q  <= '0;
                addr_cnt_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start && !bus.test_mode) begin
                            vec_q      <= bus.vec_count;
                            row_cnt_q  <= '0;
                            addr_cnt_q <= '0;
                            if (vec_bad) begin
                                state_q <= S_ERR;
                                error_q <= 1'b1;
                            end else begin
                                state_q       <= S_ALLOC;
                                error_q       <= 1'b0;
                                alloc_start_q <= 1'b1;
                            end
                        end
                    end
                    S_ALLOC: begin
                        if (bus.recovery_done) begin
                            if (bus.recovery_success) begin
                                state_q <= S_LOAD_W;
                            end else begin
                                state_q <= S_ERR;
                                error_q <= 1'b1;
                            end
                        end
                    end
                    S_LOAD_W: begin
                        if (bus.w_in_valid) begin
                            if (row_cnt_q == ROW_LAST) begin
                                state_q   <= S_STREAM;
                                row_cnt_q <= '0;
                            end else begin
                                row_cnt_q <= row_cnt_q + 1'b1;
                            end
                        end
                    end
                    S_STREAM: begin
                        if ({1'b0, addr_cnt_q} == vec_q - 1'b1) begin
                            state_q    <= S_DRAIN;
                            addr_cnt_q <= '0;
                        end else begin
                            addr_cnt_q <= addr_cnt_q + 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (!pending) begin
                            state_q <= S_FIN;
                        end
                    end
                    S_FIN:   state_q <= S_IDLE;
                    S_ERR:   state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Shift the read strobe/address through the array latency every cycle;
    // an abort empties it so no stale write reaches the accumulator.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            for (int i = 0; i < ARRAY_LATENCY; i++) begin
                dl_vld_q[i]  <= 1'b0;
                dl_addr_q[i] <= '0;
            end
        end else begin
            dl_vld_q[0]  <= rd_en;
            dl_addr_q[0] <= rd_addr;
            for (int i = 1; i < ARRAY_LATENCY; i++) begin
                dl_vld_q[i]  <= dl_vld_q[i-1];
                dl_addr_q[i] <= dl_addr_q[i-1];
            end
        end
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_FIN) || (state_q == S_ERR);
    assign bus.error        = error_q;
    assign bus.aborted      = aborted_q;
    assign bus.alloc_start  = alloc_start_q;
    assign bus.w_in_ready   = w_ready;
    assign bus.weight_valid = bus.w_in_valid & w_ready;
    assign bus.act_rd_en    = rd_en;
    assign bus.act_rd_addr  = rd_addr;
    assign bus.acc_wr_en    = dl_vld_q[ARRAY_LATENCY-1];
    assign bus.acc_wr_addr  = dl_addr_q[ARRAY_LATENCY-1];
    assign bus.state_dbg    = state_q;

endmodule

// File: doc/strait_tile_sequencer.md
Name: strait_tile_sequencer

Overview:
Normal-mode job sequencer for the STRAIT datapath. On each tile request it does four things in order:
- triggers BISR weight allocation;
- meters SYSTOLIC_SIZE weight rows from the external source into BISR;
- issues activation_mem read addresses;
- generates latency-aligned accumulator write enables/addresses.

It sits between the host interface and the bisr_weight_allocation, Activation_mem and Accumulator write ports, and replaces hybrid_bist as the address source whenever test_mode=0.

Parameters:
SYSTOLIC_SIZE, 8, array dimension; also the number of weight rows per tile.
ADDR_WIDTH, $clog2(SYSTOLIC_SIZE), activation/accumulator address width.
ARRAY_LATENCY, 2*SYSTOLIC_SIZE, cycles from act_rd_en to the matching partial sum being valid at the Accumulator input (≥1).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
test_mode  in  1  1 = BIST owns the datapath; the sequencer aborts/idles
start  in  1  job request pulse; sampled only in IDLE
vec_count  in  ADDR_WIDTH+1  activation vectors in this tile, legal 1..SYSTOLIC_SIZE; latched on start
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse at job end (success or error)
error  out  1  sticky job-failure flag
aborted  out  1  1-cycle pulse when test_mode kills a job
alloc_start  out  1  1-cycle pulse to BISR allocation_start
recovery_done  in  1  from BISR
recovery_success  in  1  from BISR, valid with recovery_done
w_in_valid  in  1  external weight row valid
w_in_ready  out  1  sequencer accepts a weight row
weight_valid  out  1  to BISR weight_valid
act_rd_en  out  1  activation read strobe
act_rd_addr  out  ADDR_WIDTH  activation row index (BISR remaps it)
acc_wr_en  out  1  Accumulator write enable
acc_wr_addr  out  ADDR_WIDTH  Accumulator write address

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE and every counter cleared. The delay line is flushed.
- Output values in reset: all outputs 0, including error.
- States: IDLE, ALLOC, LOAD_W, STREAM, DRAIN, FIN, ERR.
- IDLE:
  - start=1 and test_mode=0: latch vec_count, clear error, go to ALLOC.
  - If vec_count is 0 or >SYSTOLIC_SIZE, go to ERR instead.
  - start while busy is ignored (no queueing).
- ALLOC:
  - alloc_start=1 only on the first cycle in ALLOC.
  - Wait for recovery_done=1. recovery_success=1 → LOAD_W; 0 → ERR.
  - recovery_done in the same cycle as alloc_start is accepted.
- LOAD_W:
  - w_in_ready=1; weight_valid = w_in_valid & w_in_ready (combinational).
  - Row counter increments per accepted row.
  - After accepting the row with counter=SYSTOLIC_SIZE-1, go to STREAM next cycle.
  - Gaps in w_in_valid stall without a timeout.
  - w_in_ready=0 in all other states.
- STREAM:
  - act_rd_en=1 every cycle, no bubbles.
  - act_rd_addr = 0,1,…,vec_count-1 on consecutive cycles.
  - After the last address, go to DRAIN.
- Delay line:
  - ARRAY_LATENCY-stage shift register of {act_rd_en, act_rd_addr}.
  - acc_wr_en/acc_wr_addr at cycle t+ARRAY_LATENCY equal act_rd_en/act_rd_addr at cycle t.
  - It shifts in every state, so the addresses written are exactly the vec_count addresses streamed.
- DRAIN: wait until no valid bit remains in the delay line, then go to FIN.
- FIN: done=1 for one cycle, then IDLE.
- ERR: done=1 and error=1 for one cycle, then IDLE. error stays 1 until the next accepted start or rst.
- test_mode rises in any non-IDLE state:
  - Next cycle: state=IDLE, delay line flushed, aborted=1 for one cycle.
  - done is not pulsed and error is unchanged.
  - acc_wr_en is 0 from that cycle on.
- While test_mode=1 in IDLE: all strobes stay 0 and start is ignored.
- Simultaneous rst and any event: rst wins.
- Job length, success case: 1 (ALLOC entry) + allocation wait + SYSTOLIC_SIZE accepted rows + vec_count + ARRAY_LATENCY + 1 (FIN).

Test Plan:
- SIZE=8, LAT=16, vec_count=8, recovery_done 3 cycles after alloc_start with success=1, w_in_valid always 1 → 8 weight_valid pulses; act_rd_addr 0..7 on consecutive cycles; acc_wr_addr 0..7 exactly 16 cycles later; done one cycle after last acc_wr_en; error=0.
- recovery_success=0 → no weight_valid, no act_rd_en; done=1 and error=1 same cycle; error held until next start.
- w_in_valid toggling 1,0,0,1,… → exactly 8 weight_valid pulses, each only where w_in_valid=1; STREAM begins only after the 8th accepted row.
- vec_count=3 → act_rd_addr 0,1,2 only; exactly 3 acc_wr_en pulses; vec_count=0 → immediate ERR (done+error, no alloc_start).
- test_mode raised in mid-STREAM, 2nd vector → aborted pulse next cycle; no further act_rd_en or acc_wr_en; no done; busy=0.
- rst asserted during DRAIN → all outputs 0 next cycle; a subsequent start runs a full correct job.
